screen_scanout: RTL and testbench

//  Initiator side of the CPU screen-read port (scr_read/scr_read_idx/scr_read_byte/scr_read_ack).
//  On each frame trigger it reads all 256 bytes of screen memory (32 lines x 8 bytes) from the CPU.
//  It serialises them into a 64x32 pixel stream with a valid/ready handshake for the display driver.
//  It holds one prefetched byte so memory reads overlap pixel shifting.

---
 rtl/screen_scanout.sv | 145 ++++++++++++++
 tb/tb_screen_scanout.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_scanout.sv
// Frame scanout: fetches 256 screen bytes over the CPU read port and streams
// them as 64x32 pixels, keeping one prefetched byte so fetches overlap shifting.
module screen_scanout #(
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       scr_read,
   output logic [7:0] scr_read_idx,
   input  logic [7:0] scr_read_byte,
   input  logic       scr_read_ack,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic       pix_data,
   output logic [5:0] pix_x,
   output logic [4:0] pix_y,
   output logic       frame_start,
   output logic       busy,
   output logic       frame_done
);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {M_IDLE, M_WAIT, M_GAP} m_state_t;
   typedef enum logic [1:0] {P_IDLE, P_LOAD, P_SHIFT} p_state_t;

   m_state_t m_state, m_next;
   p_state_t p_state, p_next;

   logic [GW-1:0] gap_cnt;
   logic [8:0]    f_idx;
   logic [7:0]    slot;
   logic          slot_full;
   logic [7:0]    shreg;
   logic [10:0]   p;
   logic          pending;

   logic accept, last_bit, last_pix, restart, start_go;
   logic ack_take, issue, load, finish;

   assign pix_valid   = (p_state == P_SHIFT);
   assign pix_data    = shreg[7];
   assign pix_x       = p[5:0];
   assign pix_y       = p[10:6];
   assign frame_start = pix_valid && (p == 11'd0);

   assign accept   = pix_valid && pix_ready;
   assign last_bit = (p[2:0] == 3'b111);
   assign last_pix = &p;
   assign restart  = pending || start;
   assign start_go = (p_state == P_IDLE) && (start || pending);
   assign ack_take = (m_state == M_WAIT) && scr_read_ack;
   assign issue    = (m_state == M_IDLE) && busy && !slot_full && !f_idx[8];
   assign finish   = accept && last_pix;
   // On the last bit of a byte the slot goes straight into the shifter so a
   // full slot keeps the pixel stream gap-free.
   assign load     = slot_full && ((p_state == P_LOAD) ||
                                   (accept && last_bit && !last_pix));

   always_comb begin
      m_next = m_state;
      case (m_state)
         M_IDLE:  if (issue) m_next = M_WAIT;
         M_WAIT:  if (scr_read_ack) m_next = M_GAP;
         M_GAP:   if (gap_cnt == '0) m_next = M_IDLE;
         default: m_next = M_IDLE;
      endcase
   end

   always_comb begin
      p_next = p_state;
      case (p_state)
         P_IDLE:  if (start_go) p_next = P_LOAD;
         P_LOAD:  if (slot_full) p_next = P_SHIFT;
         P_SHIFT: begin
            if (accept && last_bit) begin
               if (last_pix)       p_next = restart ? P_LOAD : P_IDLE;
               else if (slot_full) p_next = P_SHIFT;
               else                p_next = P_LOAD;
            end
         end
         default: p_next = P_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= M_IDLE;
         p_state <= P_IDLE;
      end else begin
         m_state <= m_next;
         p_state <= p_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt      <= '0;
         scr_read     <= 1'b0;
         scr_read_idx <= 8'd0;
         f_idx        <= 9'd0;
         slot         <= 8'd0;
         slot_full    <= 1'b0;
         shreg        <= 8'd0;
         p            <= 11'd0;
         busy         <= 1'b0;
         pending      <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         if (ack_take)
            gap_cnt <= GW'(GAP_CYCLES - 1);
         else if (m_state == M_GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;

         if (issue) begin
            scr_read     <= 1'b1;
            scr_read_idx <= f_idx[7:0];
         end else if (ack_take) begin
            scr_read <= 1'b0;
         end

         // f_idx is 9 bits so 256 means every byte of the frame was fetched
         if (start_go || (finish && restart)) f_idx <= 9'd0;
         else if (ack_take)                   f_idx <= f_idx + 9'd1;

         if (ack_take) slot <= scr_read_byte;
         if (load)          slot_full <= 1'b0;
         else if (ack_take) slot_full <= 1'b1;

         if (load)        shreg <= slot;
         else if (accept) shreg <= {shreg[6:0], 1'b0};

         if (start_go)    p <= 11'd0;
         else if (accept) p <= p + 11'd1;

         if (start_go)                busy <= 1'b1;
         else if (finish && !restart) busy <= 1'b0;

         if (finish || start_go)  pending <= 1'b0;
         else if (start && busy)  pending <= 1'b1;

         frame_done <= finish;
      end
   end
endmodule

// File: tb/tb_screen_scanout.sv
// Bench for screen_scanout: CPU ack model plus pixel scoreboard, driven by
// directed frames with hand-chosen screen contents.
module tb_screen_scanout;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       scr_read;
   logic [7:0] scr_read_idx;
   logic [7:0] scr_read_byte;
   logic       scr_read_ack;
   logic       pix_valid;
   logic       pix_ready;
   logic       pix_data;
   logic [5:0] pix_x;
   logic [4:0] pix_y;
   logic       frame_start;
   logic       busy;
   logic       frame_done;

   screen_scanout #(.GAP_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .scr_read(scr_read), .scr_read_idx(scr_read_idx),
      .scr_read_byte(scr_read_byte), .scr_read_ack(scr_read_ack),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [256];
   int          lat = 2;
   int          big_idx = -1;
   int          big_lat = 0;
   logic        rdy_rand = 1'b0;
   int          stray_req = 0;

   int          checks = 0;
   int          errors = 0;
   logic [12:0] sb [$];
   int          fd_cnt = 0, fs_cnt = 0, lit_cnt = 0, acc_cnt = 0;
   int          req_cnt = 0, busy_fall = 0;
   logic [7:0]  row7 = 8'd0;
   logic [7:0]  first_idx = 8'hEE;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_frame();
      logic [10:0] pv;
      logic [7:0]  b;
      for (int i = 0; i < 2048; i++) begin
         pv = 11'(i);
         b  = mem[pv[10:3]];
         sb.push_back({pv == 11'd0, b[3'd7 - pv[2:0]], pv[10:6], pv[5:0]});
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
   endtask

   task automatic wait_fd(input int target, input int budget, input string nm);
      int n = 0;
      while (fd_cnt < target && n < budget) begin
         @(posedge clk); n++;
      end
      check(nm, 32'(fd_cnt >= target), 32'd1);
   endtask

   task automatic wait_req(input logic [7:0] idx, input int budget, input string nm);
      int n = 0;
      while (!(scr_read && scr_read_idx == idx) && n < budget) begin
         @(posedge clk); #2 n++;
      end
      check(nm, 32'(scr_read && scr_read_idx == idx), 32'd1);
   endtask

   // CPU side: ack after a per-index latency; also injects stray acks on request
   initial begin
      int cnt = 0;
      int stray_done = 0;
      scr_read_ack = 1'b0;
      scr_read_byte = 8'd0;
      pix_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         scr_read_ack = 1'b0;
         scr_read_byte = 8'd0;
         if (stray_req != stray_done) begin
            stray_done = stray_req;
            scr_read_ack = 1'b1;
            scr_read_byte = 8'hFF;
         end else if (rst_n && scr_read) begin
            cnt++;
            if (cnt >= ((int'(scr_read_idx) == big_idx) ? big_lat : lat)) begin
               scr_read_ack = 1'b1;
               scr_read_byte = mem[scr_read_idx];
            end
         end else begin
            cnt = 0;
         end
         pix_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: request ordering/stability and pixel scoreboard
   initial begin
      logic        prev_req = 1'b0, prev_busy = 1'b0, stall = 1'b0, first_pend = 1'b0;
      logic [7:0]  exp_idx = 8'd0, held_idx = 8'd0;
      logic [12:0] saved = '0, got, exp;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            exp_idx = 8'd0; prev_req = 1'b0; prev_busy = 1'b0; stall = 1'b0;
            first_pend = 1'b1; first_idx = 8'hEE;
         end else begin
            if (scr_read && !prev_req) begin
               check("req_idx_order", 32'(scr_read_idx), 32'(exp_idx));
               if (first_pend) begin first_idx = scr_read_idx; first_pend = 1'b0; end
               exp_idx++; req_cnt++; held_idx = scr_read_idx;
            end else if (scr_read) begin
               check("req_idx_hold", 32'(scr_read_idx), 32'(held_idx));
            end
            prev_req = scr_read;
            got = {frame_start, pix_data, pix_y, pix_x};
            if (stall) begin
               check("stall_valid", 32'(pix_valid), 32'd1);
               check("stall_hold", 32'(got), 32'(saved));
            end
            if (pix_valid && pix_ready) begin
               if (sb.size() == 0) begin
                  check("pix_unexpected", 32'(got), 32'h1FFF_FFFF);
               end else begin
                  exp = sb.pop_front();
                  check("pix", 32'(got), 32'(exp));
               end
               acc_cnt++;
               if (pix_data) lit_cnt++;
               if (frame_start) fs_cnt++;
               if (pix_y == 5'd7 && pix_x >= 6'd16 && pix_x <= 6'd23)
                  row7[3'd7 - 3'(pix_x - 6'd16)] = pix_data;
            end
            stall = pix_valid && !pix_ready;
            saved = got;
            if (frame_done) fd_cnt++;
            if (prev_busy && !busy) busy_fall++;
            prev_busy = busy;
         end
      end
   end

   initial begin
      int fd0, fs0, lit0, acc0, req0, bf0;
      foreach (mem[i]) mem[i] = 8'd0;

      // reset state
      #3;
      check("rst_scr_read", 32'(scr_read), 32'd0);
      check("rst_idx", 32'(scr_read_idx), 32'd0);
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_pix", 32'({frame_start, pix_data, pix_y, pix_x}), 32'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // corners lit, immediate consumer, 2-cycle CPU
      mem[0] = 8'h80; mem[255] = 8'h01;
      fd0 = fd_cnt; fs0 = fs_cnt; lit0 = lit_cnt; acc0 = acc_cnt; req0 = req_cnt;
      push_frame();
      pulse_start();
      wait_fd(fd0 + 1, 10000, "t1_done");
      repeat (20) @(posedge clk);
      check("t1_frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);
      check("t1_frame_start_cnt", 32'(fs_cnt - fs0), 32'd1);
      check("t1_lit_cnt", 32'(lit_cnt - lit0), 32'd2);
      check("t1_pix_cnt", 32'(acc_cnt - acc0), 32'd2048);
      check("t2_req_cnt", 32'(req_cnt - req0), 32'd256);
      check("t1_sb_empty", 32'(sb.size()), 32'd0);
      check("t1_busy_after", 32'(busy), 32'd0);

      // CPU stalls 500 cycles on idx 0x10
      big_idx = 8'h10; big_lat = 500;
      acc0 = acc_cnt; fd0 = fd_cnt;
      push_frame();
      pulse_start();
      wait_req(8'h10, 2000, "t3_req_10");
      repeat (300) @(posedge clk);
      #2;
      check("t3_read_held", 32'(scr_read), 32'd1);
      check("t3_idx_held", 32'(scr_read_idx), 32'h10);
      check("t3_pix_before_stall", 32'(acc_cnt - acc0), 32'd128);
      check("t3_stalled_valid", 32'(pix_valid), 32'd0);
      wait_fd(fd0 + 1, 5000, "t3_done");
      big_idx = -1;

      // random backpressure, byte 0x3A = 0xA5
      foreach (mem[i]) mem[i] = 8'(i * 7 + 3);
      mem[8'h3A] = 8'hA5;
      rdy_rand = 1'b1;
      fd0 = fd_cnt;
      push_frame();
      pulse_start();
      wait_fd(fd0 + 1, 20000, "t4_done");
      check("t4_row7_bits", 32'(row7), 32'hA5);
      check("t4_sb_empty", 32'(sb.size()), 32'd0);
      rdy_rand = 1'b0;
      repeat (5) @(posedge clk);

      // three starts mid-frame merge into one extra frame
      fd0 = fd_cnt; acc0 = acc_cnt; req0 = req_cnt; bf0 = busy_fall; fs0 = fs_cnt;
      push_frame();
      push_frame();
      pulse_start();
      repeat (500) @(posedge clk);
      pulse_start();
      repeat (100) @(posedge clk);
      pulse_start();
      repeat (100) @(posedge clk);
      pulse_start();
      wait_fd(fd0 + 2, 10000, "t5_done");
      repeat (300) @(posedge clk);
      check("t5_frames", 32'(fd_cnt - fd0), 32'd2);
      check("t5_busy_falls", 32'(busy_fall - bf0), 32'd1);
      check("t5_pix_cnt", 32'(acc_cnt - acc0), 32'd4096);
      check("t5_req_cnt", 32'(req_cnt - req0), 32'd512);
      check("t5_frame_starts", 32'(fs_cnt - fs0), 32'd2);

      // reset while waiting on idx 0x40, then a stray ack
      big_idx = 8'h40; big_lat = 100;
      fd0 = fd_cnt;
      push_frame();
      pulse_start();
      wait_req(8'h40, 3000, "t6_req_40");
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("t6_rst_scr_read", 32'(scr_read), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_pix_valid", 32'(pix_valid), 32'd0);
      check("t6_rst_idx", 32'(scr_read_idx), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      big_idx = -1;
      stray_req++;
      repeat (10) @(posedge clk);
      #2;
      check("t6_stray_scr_read", 32'(scr_read), 32'd0);
      check("t6_stray_busy", 32'(busy), 32'd0);
      check("t6_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
      acc0 = acc_cnt;
      push_frame();
      pulse_start();
      wait_fd(fd0 + 1, 10000, "t6_done");
      check("t6_first_idx", 32'(first_idx), 32'd0);
      check("t6_pix_cnt", 32'(acc_cnt - acc0), 32'd2048);
      check("t6_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
